// File: rtl/fp_mul_pipe_pkg.sv
// ============================================================================
// Module   : fp_mul_pkg
// Purpose  : Shared types and helpers for the pipelined floating-point multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mul_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } r_mode_e;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        NORM = 2'b01,
        INF  = 2'b10,
        NAN  = 2'b11
    } op_class_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Bit pattern of the canonical quiet NaN, right-aligned in 64 bits.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int frc_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= frc_w && i < frc_w + exp_w) v[i] = 1'b1;
        end
        v[frc_w-1] = 1'b1;
        return v;
    endfunction

    // Subnormals land in ZERO: they are flushed on input.
    function automatic op_class_e classify(input logic e_zero, input logic e_ones,
                                           input logic f_nz);
        if (e_zero)      return ZERO;
        else if (!e_ones) return NORM;
        else if (f_nz)   return NAN;
        else             return INF;
    endfunction

    function automatic r_mode_e decode_mode(input logic [2:0] m);
        case (m)
            3'b001:  return RTZ;
            3'b010:  return RDN;
            3'b011:  return RUP;
            3'b100:  return RMM;
            default: return RNE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_pipe_if.sv
// ============================================================================
// Module   : fp_mul_pipe_if
// Purpose  : Operand/result handshake bundle for fp_mul_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
);
    localparam int W = 1 + EXP_W + FRC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fp_X;
    logic [W-1:0] fp_Y;
    logic [2:0]   r_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fp_Z;
    logic         ovrf;
    logic         udrf;
    logic         inv;

    modport master (
        output in_valid, fp_X, fp_Y, r_mode, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf, inv
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, r_mode, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf, inv
    );
endinterface

`default_nettype wire

// File: rtl/fp_mul_pipe_round.sv
// ============================================================================
// Module   : fp_mul_round
// Purpose  : Combinational five-mode rounder with overflow/underflow saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic [FRC_W:0]          sig_i,
    input  logic                    g_i,
    input  logic                    r_i,
    input  logic                    s_i,
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  r_mode_e                 mode_i,
    output logic [FRC_W-1:0]        frac_o,
    output logic [EXP_W-1:0]        exp_o,
    output logic                    ovrf_o,
    output logic                    udrf_o
);
    localparam logic signed [EXP_W+1:0] ONE_E  = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EMAX_E = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] ZERO_E = '0;

    logic                    inc;
    logic [FRC_W+1:0]        sum;
    logic [FRC_W-1:0]        frac_r;
    logic signed [EXP_W+1:0] exp_r;
    logic                    sat;

    always_comb begin
        case (mode_i)
            RNE:     inc = g_i & (r_i | s_i | sig_i[0]);
            RMM:     inc = g_i;
            RUP:     inc = !sign_i & (g_i | r_i | s_i);
            RDN:     inc = sign_i & (g_i | r_i | s_i);
            default: inc = 1'b0;
        endcase

        sum    = {1'b0, sig_i} + {{(FRC_W+1){1'b0}}, inc};
        frac_r = sum[FRC_W+1] ? sum[FRC_W:1] : sum[FRC_W-1:0];
        exp_r  = sum[FRC_W+1] ? exp_i + ONE_E : exp_i;

        ovrf_o = (exp_r >= EMAX_E);
        udrf_o = (exp_r <= ZERO_E);

        // Directed modes saturate to max finite when rounding toward zero magnitude.
        sat = (mode_i == RTZ) | ((mode_i == RUP) & sign_i) | ((mode_i == RDN) & !sign_i);

        if (ovrf_o) begin
            exp_o  = sat ? {{(EXP_W-1){1'b1}}, 1'b0} : {EXP_W{1'b1}};
            frac_o = sat ? {FRC_W{1'b1}} : {FRC_W{1'b0}};
        end else if (udrf_o) begin
            exp_o  = '0;
            frac_o = '0;
        end else begin
            exp_o  = exp_r[EXP_W-1:0];
            frac_o = frac_r;
        end
    end
endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ============================================================================
// Module   : fp_mul_pipe
// Purpose  : Pipelined IEEE-754-style multiplier with valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_pipe_if.slave bus
);
    localparam int W      = 1 + EXP_W + FRC_W;
    localparam int PW     = 2 * (FRC_W + 1);
    localparam int BIAS_I = bias(EXP_W);
    localparam logic signed [EXP_W+1:0] BIAS_E = BIAS_I[EXP_W+1:0];
    localparam logic signed [EXP_W+1:0] ONE_E  = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic [63:0]  QNAN_64 = qnan_bits(EXP_W, FRC_W);
    localparam logic [W-1:0] QNAN    = QNAN_64[W-1:0];

    // Operand capture rank
    logic v1_q, sign1_q, spec1_q, inv1_q;
    logic [EXP_W-1:0] ex1_q, ey1_q;
    logic [FRC_W-1:0] fx1_q, fy1_q;
    logic [W-1:0] sval1_q;
    r_mode_e mode1_q;
    // Product rank
    logic v2_q, sign2_q, spec2_q, inv2_q;
    logic [PW-1:0] prod2_q;
    logic signed [EXP_W+1:0] exp2_q;
    logic [W-1:0] sval2_q;
    r_mode_e mode2_q;
    // Normalise rank
    logic v3_q, sign3_q, spec3_q, inv3_q, g3_q, r3_q, s3_q;
    logic [FRC_W:0] sig3_q;
    logic signed [EXP_W+1:0] exp3_q;
    logic [W-1:0] sval3_q;
    r_mode_e mode3_q;
    // Output rank
    logic out_valid_q, ovrf_q, udrf_q, inv_q;
    logic [W-1:0] z_q;

    logic adv;
    assign adv          = !out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.fp_Z     = z_q;
    assign bus.ovrf     = ovrf_q;
    assign bus.udrf     = udrf_q;
    assign bus.inv      = inv_q;

    logic [EXP_W-1:0] ex, ey;
    logic [FRC_W-1:0] fx, fy;
    op_class_e cx, cy;
    assign ex = bus.fp_X[W-2:FRC_W];
    assign ey = bus.fp_Y[W-2:FRC_W];
    assign fx = bus.fp_X[FRC_W-1:0];
    assign fy = bus.fp_Y[FRC_W-1:0];
    assign cx = classify(ex == '0, &ex, |fx);
    assign cy = classify(ey == '0, &ey, |fy);

    logic sign_d, spec_d, inv_d;
    logic [W-1:0] sval_d;
    always_comb begin
        sign_d = bus.fp_X[W-1] ^ bus.fp_Y[W-1];
        spec_d = 1'b1;
        inv_d  = 1'b0;
        sval_d = '0;
        if (cx == NAN || cy == NAN) begin
            sval_d = QNAN;
        end else if ((cx == INF && cy == ZERO) || (cx == ZERO && cy == INF)) begin
            sval_d = QNAN;
            inv_d  = 1'b1;
        end else if (cx == INF || cy == INF) begin
            sval_d = {sign_d, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end else if (cx == ZERO || cy == ZERO) begin
            sval_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic [PW-1:0] prod_d;
    logic signed [EXP_W+1:0] esum_d;
    assign prod_d = PW'({1'b1, fx1_q}) * PW'({1'b1, fy1_q});
    assign esum_d = $signed({2'b00, ex1_q}) + $signed({2'b00, ey1_q}) - BIAS_E;

    // Pre-shift so the hidden bit always sits at the MSB; sticky spans the full width.
    logic [PW-1:0] pn;
    logic [FRC_W:0] sig_d;
    logic g_d, r_d, s_d;
    logic signed [EXP_W+1:0] exp3_d;
    assign pn     = prod2_q[PW-1] ? prod2_q : (prod2_q << 1);
    assign sig_d  = pn[PW-1 -: FRC_W+1];
    assign g_d    = pn[PW-FRC_W-2];
    assign r_d    = pn[PW-FRC_W-3];
    assign s_d    = |pn[PW-FRC_W-4:0];
    assign exp3_d = prod2_q[PW-1] ? exp2_q + ONE_E : exp2_q;

    logic [FRC_W-1:0] frac_r;
    logic [EXP_W-1:0] exp_r;
    logic ovrf_r, udrf_r;

    fp_mul_round #(.EXP_W(EXP_W), .FRC_W(FRC_W)) u_round (
        .sig_i  (sig3_q),
        .g_i    (g3_q),
        .r_i    (r3_q),
        .s_i    (s3_q),
        .sign_i (sign3_q),
        .exp_i  (exp3_q),
        .mode_i (mode3_q),
        .frac_o (frac_r),
        .exp_o  (exp_r),
        .ovrf_o (ovrf_r),
        .udrf_o (udrf_r)
    );

    logic [W-1:0] z_d;
    assign z_d = !v3_q ? '0 : (spec3_q ? sval3_q : {sign3_q, exp_r, frac_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
            inv_q       <= 1'b0;
        end else if (adv) begin
            v1_q    <= bus.in_valid;
            sign1_q <= sign_d;
            spec1_q <= spec_d;
            inv1_q  <= inv_d;
            sval1_q <= sval_d;
            ex1_q   <= ex;
            ey1_q   <= ey;
            fx1_q   <= fx;
            fy1_q   <= fy;
            mode1_q <= decode_mode(bus.r_mode);

            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            spec2_q <= spec1_q;
            inv2_q  <= inv1_q;
            sval2_q <= sval1_q;
            prod2_q <= prod_d;
            exp2_q  <= esum_d;
            mode2_q <= mode1_q;

            v3_q    <= v2_q;
            sign3_q <= sign2_q;
            spec3_q <= spec2_q;
            inv3_q  <= inv2_q;
            sval3_q <= sval2_q;
            sig3_q  <= sig_d;
            g3_q    <= g_d;
            r3_q    <= r_d;
            s3_q    <= s_d;
            exp3_q  <= exp3_d;
            mode3_q <= mode2_q;

            out_valid_q <= v3_q;
            z_q         <= z_d;
            ovrf_q      <= v3_q & !spec3_q & ovrf_r;
            udrf_q      <= v3_q & !spec3_q & udrf_r;
            inv_q       <= v3_q & spec3_q & inv3_q;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
// ============================================================================
// Module   : tb_fp_mul_pipe
// Purpose  : Directed self-checking bench for fp_mul_pipe (single and double).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8),  .FRC_W(23)) b32 ();
    fp_mul_pipe_if #(.EXP_W(11), .FRC_W(52)) b64 ();

    fp_mul_pipe #(.EXP_W(8),  .FRC_W(23)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    fp_mul_pipe #(.EXP_W(11), .FRC_W(52)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    // Drives one beat, waits (bounded) for its result; lat = -1 on timeout.
    task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                           output logic [31:0] z, output logic [2:0] fl, output int lat);
        @(negedge clk);
        b32.in_valid  = 1'b1;
        b32.fp_X      = x;
        b32.fp_Y      = y;
        b32.r_mode    = m;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        lat = -1;
        z   = '0;
        fl  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b32.out_valid) begin
                lat = k;
                z   = b32.fp_Z;
                fl  = {b32.ovrf, b32.udrf, b32.inv};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.fp_Z !== 32'h0 ||
            {b32.ovrf, b32.udrf, b32.inv} !== 3'b000) begin
            bad++;
            $display("FAIL reset_state: got ov=%b ir=%b z=%h fl=%b want ov=0 ir=1 z=0 fl=000",
                     b32.out_valid, b32.in_ready, b32.fp_Z, {b32.ovrf, b32.udrf, b32.inv});
        end
    endtask

    task automatic test_basic();
        logic [31:0] z; logic [2:0] fl; int lat;
        issue32(32'h40400000, 32'h40400000, 3'b001, z, fl, lat);
        total++;
        if (z !== 32'h41100000 || fl !== 3'b000) begin
            bad++; $display("FAIL mul_3x3: got z=%h fl=%b want z=41100000 fl=000", z, fl);
        end
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL latency_3x3: got %0d want 3", lat);
        end
        issue32(32'h3FC00000, 32'h3FC00000, 3'b001, z, fl, lat);
        total++;
        if (z !== 32'h40100000 || fl !== 3'b000) begin
            bad++; $display("FAIL mul_1p5sq: got z=%h fl=%b want z=40100000 fl=000", z, fl);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] z; logic [2:0] fl; int lat;
        logic [31:0] xs  [6] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                 32'h3F800001, 32'hBF800001};
        logic [2:0]  ms  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] exs [6] = '{32'h3F800002, 32'h3F800002, 32'h3F800002, 32'h3F800003,
                                 32'h3F800002, 32'hBF800003};
        for (int i = 0; i < 6; i++) begin
            issue32(xs[i], 32'h3F800001, ms[i], z, fl, lat);
            total++;
            if (z !== exs[i] || fl !== 3'b000) begin
                bad++;
                $display("FAIL round_%0d mode=%b: got z=%h fl=%b want z=%h fl=000",
                         i, ms[i], z, fl, exs[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] z; logic [2:0] fl; int lat;
        logic [31:0] xs  [7] = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000,
                                 32'hFF000000, 32'h7F000000, 32'h00800000};
        logic [31:0] ys  [7] = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000,
                                 32'h7F000000, 32'h7F000000, 32'h3F000000};
        logic [2:0]  ms  [7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b011, 3'b100, 3'b000};
        logic [31:0] exs [7] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF,
                                 32'hFF7FFFFF, 32'h7F800000, 32'h00000000};
        logic [2:0]  efs [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
        for (int i = 0; i < 7; i++) begin
            issue32(xs[i], ys[i], ms[i], z, fl, lat);
            total++;
            if (z !== exs[i] || fl !== efs[i]) begin
                bad++;
                $display("FAIL range_%0d: got z=%h fl=%b want z=%h fl=%b",
                         i, z, fl, exs[i], efs[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] z; logic [2:0] fl; int lat;
        logic [31:0] xs  [5] = '{32'h7F800000, 32'hFF800000, 32'h00000001, 32'h7FC00001,
                                 32'h3F800000};
        logic [31:0] ys  [5] = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'h3F800000,
                                 32'hFF800001};
        logic [31:0] exs [5] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000,
                                 32'h7FC00000};
        logic [2:0]  efs [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 5; i++) begin
            issue32(xs[i], ys[i], 3'b000, z, fl, lat);
            total++;
            if (z !== exs[i] || fl !== efs[i]) begin
                bad++;
                $display("FAIL special_%0d: got z=%h fl=%b want z=%h fl=%b",
                         i, z, fl, exs[i], efs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs  [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000};
        logic [31:0] exs [6] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                 32'h41200000, 32'h41400000};
        logic [31:0] got [6];
        int sent = 0, nres = 0, stall_bad = 0, stalls = 0;
        logic [31:0] held = '0;
        logic acc, drn, prev_stall = 1'b0;
        for (int cyc = 1; cyc <= 40 && nres < 6; cyc++) begin
            @(negedge clk);
            b32.out_ready = !(cyc >= 4 && cyc <= 6);
            b32.in_valid  = (sent < 6);
            b32.fp_X      = xs[sent < 6 ? sent : 0];
            b32.fp_Y      = 32'h40000000;
            b32.r_mode    = 3'b000;
            #1;
            if (b32.out_valid && !b32.out_ready) begin
                stalls++;
                if (b32.in_ready !== 1'b0) stall_bad++;
                if (prev_stall && b32.fp_Z !== held) stall_bad++;
                held       = b32.fp_Z;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            acc = b32.in_valid & b32.in_ready;
            drn = b32.out_valid & b32.out_ready;
            if (drn && nres < 6) got[nres] = b32.fp_Z;
            @(posedge clk);
            if (acc) sent++;
            if (drn) nres++;
        end
        #1 b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        total++;
        if (stall_bad != 0 || stalls != 2) begin
            bad++;
            $display("FAIL stall_behaviour: got stalls=%0d errors=%0d want stalls=2 errors=0",
                     stalls, stall_bad);
        end
        total++;
        if (nres != 6) begin
            bad++; $display("FAIL stream_count: got %0d results want 6", nres);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= nres || got[i] !== exs[i]) begin
                bad++;
                $display("FAIL stream_%0d: got %h want %h", i, (i < nres) ? got[i] : 32'hx,
                         exs[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [31:0] z; logic [2:0] fl; int lat;
        int leaked = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b32.in_valid  = 1'b1;
            b32.fp_X      = 32'h40400000;
            b32.fp_Y      = 32'h40400000;
            b32.r_mode    = 3'b000;
            b32.out_ready = 1'b1;
        end
        @(negedge clk);
        b32.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (b32.out_valid !== 1'b0 || b32.fp_Z !== 32'h0 ||
            {b32.ovrf, b32.udrf, b32.inv} !== 3'b000 || b32.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: got ov=%b z=%h fl=%b ir=%b want 0/0/000/1",
                     b32.out_valid, b32.fp_Z, {b32.ovrf, b32.udrf, b32.inv}, b32.in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (b32.out_valid) leaked++;
        end
        total++;
        if (leaked != 0) begin
            bad++; $display("FAIL midreset_drop: got %0d leaked results want 0", leaked);
        end
        issue32(32'h3FC00000, 32'h3FC00000, 3'b000, z, fl, lat);
        total++;
        if (lat !== 3 || z !== 32'h40100000) begin
            bad++;
            $display("FAIL midreset_after: got lat=%0d z=%h want lat=3 z=40100000", lat, z);
        end
    endtask

    task automatic test_double();
        logic [63:0] z = '0;
        int lat = -1;
        @(negedge clk);
        b64.in_valid = 1'b1;
        b64.fp_X     = 64'h4008000000000000;
        b64.fp_Y     = 64'h4008000000000000;
        b64.r_mode   = 3'b000;
        @(posedge clk);
        #1 b64.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b64.out_valid) begin
                lat = k;
                z   = b64.fp_Z;
                break;
            end
        end
        total++;
        if (lat !== 3 || z !== 64'h4022000000000000) begin
            bad++;
            $display("FAIL double_3x3: got lat=%0d z=%h want lat=3 z=4022000000000000", lat, z);
        end
    endtask

    initial begin
        rst           = 1'b1;
        b32.in_valid  = 1'b0;
        b32.fp_X      = '0;
        b32.fp_Y      = '0;
        b32.r_mode    = 3'b000;
        b32.out_ready = 1'b1;
        b64.in_valid  = 1'b0;
        b64.fp_X      = '0;
        b64.fp_Y      = '0;
        b64.r_mode    = 3'b000;
        b64.out_ready = 1'b1;

        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_mid_reset();
        test_double();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
